// File: rtl/code_lock_fsm_pkg.sv
// Channel header for the code lock loop: correlator widths, lock states, dwell sum sizing
// and the circular code-shift step.
`ifndef I2Q2_WIDTH
`define I2Q2_WIDTH 32
`endif

package code_lock_fsm_pkg;

  localparam int unsigned I2Q2_W = `I2Q2_WIDTH;
  localparam int unsigned SEEK_W = 15;

  typedef enum logic [1:0] {
    StSearch = 2'd0,
    StVerify = 2'd1,
    StLocked = 2'd2
  } lock_state_e;

  // Sums of DWELL unsigned powers need log2(DWELL) extra bits to stay exact.
  function automatic int unsigned sum_width(input int unsigned dwell);
    return I2Q2_W + $clog2(dwell);
  endfunction

  // Advance a code shift by step, wrapping circularly past limit.
  function automatic logic [SEEK_W-1:0] seek_next(input logic [SEEK_W-1:0] cur,
                                                  input logic [SEEK_W-1:0] step,
                                                  input logic [SEEK_W-1:0] limit);
    logic [SEEK_W:0] sum;
    sum = {1'b0, cur} + {1'b0, step};
    if (sum > {1'b0, limit}) begin
      sum = sum - {1'b0, limit} - {{SEEK_W{1'b0}}, 1'b1};
    end
    return sum[SEEK_W-1:0];
  endfunction

endpackage

// File: rtl/code_lock_fsm_if.sv
// Correlator power bus: one strobe qualifying early/prompt/late power samples.
interface code_lock_fsm_if;
  import code_lock_fsm_pkg::*;

  logic              i2q2_valid;
  logic [I2Q2_W-1:0] i2q2_early;
  logic [I2Q2_W-1:0] i2q2_prompt;
  logic [I2Q2_W-1:0] i2q2_late;

  modport master (
    output i2q2_valid,
    output i2q2_early,
    output i2q2_prompt,
    output i2q2_late
  );

  modport slave (
    input i2q2_valid,
    input i2q2_early,
    input i2q2_prompt,
    input i2q2_late
  );
endinterface

// File: rtl/code_lock_fsm_dwell_accumulator.sv
// Sums DWELL qualified early/prompt/late samples; done flags the sample completing a dwell,
// with the sum outputs already including that sample.
module dwell_accumulator
  import code_lock_fsm_pkg::*;
#(
  parameter int unsigned DWELL = 4,
  parameter int unsigned SUM_W = sum_width(DWELL)
) (
  input  logic             clk,
  input  logic             reset,
  code_lock_fsm_if.slave   i2q2,
  output logic             done,
  output logic [SUM_W-1:0] sum_early,
  output logic [SUM_W-1:0] sum_prompt,
  output logic [SUM_W-1:0] sum_late
);

  localparam int unsigned CntW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DWELL - 1);

  logic [SUM_W-1:0] acc_e_q, acc_p_q, acc_l_q;
  logic [CntW-1:0]  cnt_q;

  always_comb begin
    sum_early  = acc_e_q + SUM_W'(i2q2.i2q2_early);
    sum_prompt = acc_p_q + SUM_W'(i2q2.i2q2_prompt);
    sum_late   = acc_l_q + SUM_W'(i2q2.i2q2_late);
    done       = i2q2.i2q2_valid && (cnt_q == CntLast);
  end

  // Accumulators restart at zero on the completing sample, so the next valid opens a
  // fresh dwell even when it lands on the decision cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_e_q <= '0;
      acc_p_q <= '0;
      acc_l_q <= '0;
      cnt_q   <= '0;
    end else if (i2q2.i2q2_valid) begin
      if (done) begin
        acc_e_q <= '0;
        acc_p_q <= '0;
        acc_l_q <= '0;
        cnt_q   <= '0;
      end else begin
        acc_e_q <= sum_early;
        acc_p_q <= sum_prompt;
        acc_l_q <= sum_late;
        cnt_q   <= cnt_q + CntW'(1);
      end
    end
  end

endmodule

// File: rtl/code_lock_fsm.sv
// Code acquisition/tracking controller: searches code shifts, verifies hits, holds lock
// and requests half-chip slips from the early/late power balance.
module code_lock_fsm
  import code_lock_fsm_pkg::*;
#(
  parameter int unsigned        DWELL          = 4,
  parameter logic [31:0]        LOCK_THRESH    = 32'h0040_0000,
  parameter int unsigned        VERIFY_HITS    = 3,
  parameter int unsigned        LOSS_MISSES    = 2,
  parameter logic [31:0]        SLIP_MARGIN    = 32'h0001_0000,
  parameter logic [SEEK_W-1:0]  SEARCH_STEP    = 15'd8,
  parameter logic [SEEK_W-1:0]  CODE_SHIFT_MAX = 15'd16799,
  localparam int unsigned       SUM_W          = sum_width(DWELL)
) (
  input  logic              clk,
  input  logic              reset,
  code_lock_fsm_if.slave    i2q2,
  output logic              seek_en,
  output logic [SEEK_W-1:0] seek_target,
  output logic              slip_valid,
  output logic              slip_dir,
  output logic              locked,
  output logic [1:0]        state,
  output logic [SUM_W-1:0]  prompt_sum,
  output logic              sum_valid
);

  localparam int unsigned HitW  = $clog2(VERIFY_HITS + 1);
  localparam int unsigned MissW = $clog2(LOSS_MISSES + 1);
  localparam logic [HitW-1:0]  HitThr  = HitW'(VERIFY_HITS);
  localparam logic [MissW-1:0] MissThr = MissW'(LOSS_MISSES);
  localparam logic [SUM_W-1:0] LockThr = SUM_W'(LOCK_THRESH);
  localparam logic [SUM_W-1:0] SlipMar = SUM_W'(SLIP_MARGIN);

  logic             done;
  logic [SUM_W-1:0] sum_early, sum_prompt, sum_late;

  dwell_accumulator #(
    .DWELL (DWELL),
    .SUM_W (SUM_W)
  ) u_dwell (
    .clk        (clk),
    .reset      (reset),
    .i2q2       (i2q2),
    .done       (done),
    .sum_early  (sum_early),
    .sum_prompt (sum_prompt),
    .sum_late   (sum_late)
  );

  lock_state_e       state_q, state_d;
  logic [HitW-1:0]   hits_q, hits_d, hits_inc;
  logic [MissW-1:0]  misses_q, misses_d, misses_inc;
  logic [SEEK_W-1:0] seek_target_q, seek_target_d;
  logic              seek_en_q, seek_en_d;
  logic              slip_valid_q, slip_valid_d;
  logic              slip_dir_q, slip_dir_d;
  logic [SUM_W-1:0]  prompt_sum_q, prompt_sum_d;
  logic              sum_valid_q, sum_valid_d;
  logic              hit, early_gt, do_seek;
  logic [SUM_W-1:0]  el_mag;

  always_comb begin
    state_d       = state_q;
    hits_d        = hits_q;
    misses_d      = misses_q;
    seek_target_d = seek_target_q;
    seek_en_d     = 1'b0;
    slip_valid_d  = 1'b0;
    slip_dir_d    = slip_dir_q;
    prompt_sum_d  = prompt_sum_q;
    sum_valid_d   = 1'b0;
    do_seek       = 1'b0;

    hit        = (sum_prompt >= LockThr);
    early_gt   = (sum_early > sum_late);
    el_mag     = early_gt ? (sum_early - sum_late) : (sum_late - sum_early);
    hits_inc   = hits_q + HitW'(1);
    misses_inc = misses_q + MissW'(1);

    if (done) begin
      prompt_sum_d = sum_prompt;
      sum_valid_d  = 1'b1;
    end

    case (state_q)
      StSearch: begin
        if (done) begin
          if (hit) begin
            hits_d  = HitW'(1);
            state_d = (VERIFY_HITS <= 1) ? StLocked : StVerify;
          end else begin
            do_seek = 1'b1;
          end
        end
      end
      StVerify: begin
        if (done) begin
          if (hit) begin
            hits_d = hits_inc;
            if (hits_inc >= HitThr) begin
              state_d  = StLocked;
              misses_d = '0;
            end
          end else begin
            state_d = StSearch;
            hits_d  = '0;
            do_seek = 1'b1;
          end
        end
      end
      StLocked: begin
        if (done) begin
          if (hit) begin
            misses_d = '0;
            if (el_mag > SlipMar) begin
              slip_valid_d = 1'b1;
              slip_dir_d   = early_gt;
            end
          end else if (misses_inc >= MissThr) begin
            state_d  = StSearch;
            misses_d = '0;
            hits_d   = '0;
            do_seek  = 1'b1;
          end else begin
            misses_d = misses_inc;
          end
        end
      end
      default: state_d = StSearch;
    endcase

    if (do_seek) begin
      seek_en_d     = 1'b1;
      seek_target_d = seek_next(seek_target_q, SEARCH_STEP, CODE_SHIFT_MAX);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StSearch;
      hits_q        <= '0;
      misses_q      <= '0;
      seek_target_q <= '0;
      seek_en_q     <= 1'b0;
      slip_valid_q  <= 1'b0;
      slip_dir_q    <= 1'b0;
      prompt_sum_q  <= '0;
      sum_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      hits_q        <= hits_d;
      misses_q      <= misses_d;
      seek_target_q <= seek_target_d;
      seek_en_q     <= seek_en_d;
      slip_valid_q  <= slip_valid_d;
      slip_dir_q    <= slip_dir_d;
      prompt_sum_q  <= prompt_sum_d;
      sum_valid_q   <= sum_valid_d;
    end
  end

  assign seek_en     = seek_en_q;
  assign seek_target = seek_target_q;
  assign slip_valid  = slip_valid_q;
  assign slip_dir    = slip_dir_q;
  assign locked      = (state_q == StLocked);
  assign state       = state_q;
  assign prompt_sum  = prompt_sum_q;
  assign sum_valid   = sum_valid_q;

endmodule

// File: tb/tb_code_lock_fsm.sv
// Scoreboard bench for code_lock_fsm: each driven dwell pushes its expected decision,
// which is popped and compared when sum_valid appears.
module tb_code_lock_fsm;
  import code_lock_fsm_pkg::*;

  localparam int unsigned DWELL = 4;
  localparam int unsigned SUM_W = sum_width(DWELL);

  typedef struct {
    logic [63:0] cyc;
    logic [63:0] prompt;
    bit          seek_en;
    int unsigned target;
    bit          slip;
    bit          dir;
    int unsigned st;
  } exp_t;

  exp_t sb_q[$];
  exp_t exp_e;

  logic              clk = 1'b0;
  logic              reset;
  logic [63:0]       cyc = '0;
  logic              seek_en;
  logic [SEEK_W-1:0] seek_target;
  logic              slip_valid;
  logic              slip_dir;
  logic              locked;
  logic [1:0]        state;
  logic [SUM_W-1:0]  prompt_sum;
  logic              sum_valid;

  int n_checks = 0;
  int n_errors = 0;

  int unsigned m_state, m_hits, m_misses, m_target;
  bit          m_dir;

  code_lock_fsm_if i2q2 ();

  code_lock_fsm #(
    .DWELL (DWELL)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i2q2        (i2q2),
    .seek_en     (seek_en),
    .seek_target (seek_target),
    .slip_valid  (slip_valid),
    .slip_dir    (slip_dir),
    .locked      (locked),
    .state       (state),
    .prompt_sum  (prompt_sum),
    .sum_valid   (sum_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 64'd1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic model_reset();
    m_state  = 0;
    m_hits   = 0;
    m_misses = 0;
    m_target = 0;
    m_dir    = 1'b0;
  endtask

  task automatic model_decide(input logic [63:0] se, input logic [63:0] sp,
                              input logic [63:0] sl, input logic [63:0] at);
    exp_t        x;
    logic [63:0] diff;
    bit          hit, seek;
    hit    = (sp >= 64'h0040_0000);
    seek   = 1'b0;
    x.cyc    = at;
    x.prompt = sp;
    x.slip   = 1'b0;
    case (m_state)
      0: begin
        if (hit) begin
          m_state = 1;
          m_hits  = 1;
        end else seek = 1'b1;
      end
      1: begin
        if (hit) begin
          m_hits++;
          if (m_hits >= 3) begin
            m_state  = 2;
            m_misses = 0;
          end
        end else begin
          m_state = 0;
          m_hits  = 0;
          seek    = 1'b1;
        end
      end
      default: begin
        if (hit) begin
          m_misses = 0;
          diff = (se > sl) ? se - sl : sl - se;
          if (diff > 64'h0001_0000) begin
            x.slip = 1'b1;
            m_dir  = (se > sl);
          end
        end else begin
          m_misses++;
          if (m_misses >= 2) begin
            m_state  = 0;
            m_misses = 0;
            seek     = 1'b1;
          end
        end
      end
    endcase
    if (seek) begin
      m_target += 8;
      if (m_target > 16799) m_target -= 16800;
    end
    x.seek_en = seek;
    x.target  = m_target;
    x.dir     = m_dir;
    x.st      = m_state;
    sb_q.push_back(x);
  endtask

  task automatic pulse(input logic [31:0] e, input logic [31:0] p, input logic [31:0] l);
    @(negedge clk);
    i2q2.i2q2_valid  = 1'b1;
    i2q2.i2q2_early  = I2Q2_W'(e);
    i2q2.i2q2_prompt = I2Q2_W'(p);
    i2q2.i2q2_late   = I2Q2_W'(l);
  endtask

  // Idle cycles carry junk data to prove the strobe qualifies the samples.
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      i2q2.i2q2_valid  = 1'b0;
      i2q2.i2q2_early  = I2Q2_W'($urandom);
      i2q2.i2q2_prompt = I2Q2_W'($urandom);
      i2q2.i2q2_late   = I2Q2_W'($urandom);
    end
  endtask

  task automatic dwell(input logic [31:0] e, input logic [31:0] p, input logic [31:0] l,
                       input int gap);
    for (int i = 0; i < DWELL; i++) begin
      if (gap > 0) idle($urandom_range(gap, 0));
      pulse(e, p, l);
    end
    model_decide(64'(e) * 64'(DWELL), 64'(p) * 64'(DWELL), 64'(l) * 64'(DWELL),
                 cyc + 64'd1);
  endtask

  task automatic apply_reset(input int n);
    @(negedge clk);
    reset           = 1'b1;
    i2q2.i2q2_valid = 1'b0;
    repeat (n) @(negedge clk);
    check("rst_state", 64'(state), 64'd0);
    check("rst_seek_target", 64'(seek_target), 64'd0);
    check("rst_prompt_sum", 64'(prompt_sum), 64'd0);
    check("rst_pulses", 64'({seek_en, slip_valid, slip_dir, locked, sum_valid}), 64'd0);
    sb_q.delete();
    model_reset();
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (sum_valid) begin
        if (sb_q.size() == 0) begin
          check("unexpected_decision", 64'd1, 64'd0);
        end else begin
          exp_e = sb_q.pop_front();
          check("latency", cyc, exp_e.cyc);
          check("prompt_sum", 64'(prompt_sum), exp_e.prompt);
          check("seek_en", 64'(seek_en), 64'(exp_e.seek_en));
          check("seek_target", 64'(seek_target), 64'(exp_e.target));
          check("slip_valid", 64'(slip_valid), 64'(exp_e.slip));
          if (exp_e.slip) check("slip_dir", 64'(slip_dir), 64'(exp_e.dir));
          check("state", 64'(state), 64'(exp_e.st));
          check("locked", 64'(locked), 64'(exp_e.st == 2));
          check("seek_slip_excl", 64'(seek_en & slip_valid), 64'd0);
        end
      end else begin
        check("stray_pulse", 64'({seek_en, slip_valid}), 64'd0);
      end
    end
  end

  initial begin
    int guard;
    reset            = 1'b1;
    i2q2.i2q2_valid  = 1'b0;
    i2q2.i2q2_early  = '0;
    i2q2.i2q2_prompt = '0;
    i2q2.i2q2_late   = '0;
    model_reset();
    apply_reset(3);

    // Miss from reset: first seek step.
    dwell(32'h0, 32'h0, 32'h0, 0);
    // Three hits: SEARCH -> VERIFY -> VERIFY -> LOCKED, balanced E/L.
    for (int i = 0; i < 3; i++) dwell(32'h1000, 32'h0020_0000, 32'h1000, 1);

    // Slips in both directions, then the margin boundary.
    dwell(32'h0003_0000, 32'h0020_0000, 32'h0, 0);
    dwell(32'h0, 32'h0020_0000, 32'h0003_0000, 0);
    dwell(32'h0000_4000, 32'h0020_0000, 32'h0, 2);
    dwell(32'h0000_4001, 32'h0020_0000, 32'h0, 0);

    // Prompt sum exactly at threshold is a hit; one LSB short per pulse is a miss.
    dwell(32'h0, 32'h0010_0000, 32'h0, 0);
    dwell(32'h0003_0000, 32'h000F_FFFF, 32'h0, 0);
    dwell(32'h0, 32'h0020_0000, 32'h0, 0);
    dwell(32'h0, 32'h0, 32'h0003_0000, 1);
    dwell(32'h0, 32'h0, 32'h0, 0);

    // Walk the search up to the top of the code and wrap.
    guard = 0;
    while (m_target != 16792 && guard < 3000) begin
      dwell(32'h0, 32'h0, 32'h0, 0);
      guard++;
    end
    check("wrap_reached", 64'(m_target), 64'd16792);
    dwell(32'h0, 32'h0, 32'h0, 0);
    idle(1);
    check("wrap_target", 64'(seek_target), 64'd0);

    // Reset mid-dwell discards the partial sums and count.
    idle(3);
    pulse(32'h5, 32'h0030_0000, 32'h7);
    pulse(32'h5, 32'h0030_0000, 32'h7);
    apply_reset(2);
    dwell(32'h0, 32'h0, 32'h0, 1);
    idle(4);
    check("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
